// File: rtl/reset_seq_gen.sv
// Reset sequencer for one clock domain: holds NCH reset outputs until PLL lock and a
// power-on count, releases them in order, and re-asserts on lock loss, button or software request.
module reset_seq_gen #(
    parameter int NCH         = 4,
    parameter int CNTW        = 16,
    parameter int POR_CNT     = 16'hAA55,
    parameter int STAGE_GAP   = 16,
    parameter int DEB_CNT     = 1024,
    parameter int SW_HOLD     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pllLocked,
    input  logic             btnReset,
    input  logic             swResetReq,
    input  logic [NCH-1:0]   swResetMask,
    output logic [NCH-1:0]   resetOut,
    output logic             resetDone,
    output logic [1:0]       resetCause
);

    localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CNTW-1:0] POR_LAST  = CNTW'(POR_CNT - 1);
    localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(STAGE_GAP - 1);
    localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEB_CNT - 1);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(SW_HOLD - 1);
    localparam logic [KW-1:0]   K_LAST    = KW'(NCH - 1);

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_BTN  = 2'd2;
    localparam logic [1:0] CAUSE_SW   = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2,
        ST_SOFT  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] lock_sync_r;
    logic [SYNC_STAGES-1:0] btn_sync_r;
    logic                   lock_s;
    logic                   btn_s;
    logic [CNTW-1:0]        deb_cnt_r;
    logic                   btn_ok_s;

    state_t                 state_r;
    logic [CNTW-1:0]        por_cnt_r;
    logic [CNTW-1:0]        gap_cnt_r;
    logic [CNTW-1:0]        hold_cnt_r;
    logic [KW-1:0]          k_r;
    logic [NCH-1:0]         reset_out_r;
    logic                   done_r;
    logic [1:0]             cause_r;

    assign lock_s   = lock_sync_r[SYNC_STAGES-1];
    assign btn_s    = btn_sync_r[SYNC_STAGES-1];
    assign btn_ok_s = (deb_cnt_r == DEB_LAST);

    // Synchronise the asynchronous lock and button inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_sync_r <= '0;
            btn_sync_r  <= '0;
        end else begin
            lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], pllLocked};
            btn_sync_r  <= {btn_sync_r[SYNC_STAGES-2:0], btnReset};
        end
    end

    // Button debounce; left running across aborts so a held button never looks released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_cnt_r <= '0;
        end else if (!btn_s) begin
            deb_cnt_r <= '0;
        end else if (deb_cnt_r != DEB_LAST) begin
            deb_cnt_r <= deb_cnt_r + 1'b1;
        end else begin
            deb_cnt_r <= deb_cnt_r;
        end
    end

    // Sequencer FSM: abort handling first, then per-state counting and release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_HOLD;
            reset_out_r <= '1;
            done_r      <= 1'b0;
            cause_r     <= CAUSE_POR;
            por_cnt_r   <= '0;
            gap_cnt_r   <= '0;
            hold_cnt_r  <= '0;
            k_r         <= '0;
        end else if ((state_r != ST_HOLD) && (!lock_s || btn_ok_s)) begin
            state_r     <= ST_HOLD;
            reset_out_r <= '1;
            done_r      <= 1'b0;
            cause_r     <= (!lock_s) ? CAUSE_LOCK : CAUSE_BTN;
            por_cnt_r   <= '0;
            gap_cnt_r   <= '0;
            hold_cnt_r  <= '0;
            k_r         <= '0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (lock_s && !btn_ok_s) begin
                        if (por_cnt_r == POR_LAST) begin
                            state_r   <= ST_STAGE;
                            por_cnt_r <= '0;
                            gap_cnt_r <= '0;
                            k_r       <= '0;
                        end else begin
                            por_cnt_r <= por_cnt_r + 1'b1;
                        end
                    end else begin
                        por_cnt_r <= '0;
                    end
                end
                ST_STAGE: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r        <= '0;
                        reset_out_r[k_r] <= 1'b0;
                        if (k_r == K_LAST) begin
                            done_r  <= 1'b1;
                            state_r <= ST_RUN;
                        end else begin
                            k_r <= k_r + 1'b1;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (swResetReq && (swResetMask != '0)) begin
                        reset_out_r <= swResetMask;
                        done_r      <= 1'b0;
                        cause_r     <= CAUSE_SW;
                        hold_cnt_r  <= '0;
                        state_r     <= ST_SOFT;
                    end else begin
                        reset_out_r <= '0;
                    end
                end
                ST_SOFT: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        reset_out_r <= '0;
                        done_r      <= 1'b1;
                        hold_cnt_r  <= '0;
                        state_r     <= ST_RUN;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_HOLD;
                    reset_out_r <= '1;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign resetOut   = reset_out_r;
    assign resetDone  = done_r;
    assign resetCause = cause_r;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Bench for reset_seq_gen: table-driven scenarios, hand-written corner sequences and
// randomized stimulus checked against a timing-arithmetic reference model.
module tb_reset_seq_gen;

    localparam int NCH     = 4;
    localparam int POR     = 20;
    localparam int GAP     = 4;
    localparam int DEB     = 8;
    localparam int SWH     = 6;
    localparam int SYNC    = 2;
    localparam int SEQ_END = POR + NCH * GAP;

    logic           clock;
    logic           reset;
    logic           pllLocked;
    logic           btnReset;
    logic           swResetReq;
    logic [NCH-1:0] swResetMask;
    logic [NCH-1:0] resetOut;
    logic           resetDone;
    logic [1:0]     resetCause;

    reset_seq_gen #(
        .NCH(NCH), .CNTW(16), .POR_CNT(POR), .STAGE_GAP(GAP),
        .DEB_CNT(DEB), .SW_HOLD(SWH), .SYNC_STAGES(SYNC)
    ) dut (
        .clock(clock), .reset(reset), .pllLocked(pllLocked), .btnReset(btnReset),
        .swResetReq(swResetReq), .swResetMask(swResetMask),
        .resetOut(resetOut), .resetDone(resetDone), .resetCause(resetCause)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_model = 1'b0;

    // Reference model: sequencing progress as an edge count, soft reset as a countdown.
    int         m_n;
    int         m_cause;
    int         m_soft_left;
    int         m_btn_run;
    logic [3:0] m_soft_mask;
    logic       m_lock_h[SYNC];
    logic       m_btn_h[SYNC];

    task automatic model_reset();
        m_n = 0; m_cause = 0; m_soft_left = 0; m_btn_run = 0; m_soft_mask = 4'h0;
        for (int i = 0; i < SYNC; i++) begin
            m_lock_h[i] = 1'b0;
            m_btn_h[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        logic lk;
        logic bt;
        logic ok;
        lk = m_lock_h[SYNC-1];
        bt = m_btn_h[SYNC-1];
        ok = (m_btn_run >= DEB - 1);
        if (m_n < POR) begin
            m_n = (lk && !ok) ? m_n + 1 : 0;
        end else if (!lk || ok) begin
            m_n = 0;
            m_cause = (!lk) ? 1 : 2;
            m_soft_left = 0;
        end else if (m_n < SEQ_END) begin
            m_n = m_n + 1;
        end else if (m_soft_left > 0) begin
            m_soft_left = m_soft_left - 1;
        end else if (swResetReq && swResetMask != 4'h0) begin
            m_soft_left = SWH;
            m_soft_mask = swResetMask;
            m_cause = 3;
        end
        m_btn_run = bt ? ((m_btn_run < DEB) ? m_btn_run + 1 : DEB) : 0;
        for (int i = SYNC - 1; i > 0; i--) begin
            m_lock_h[i] = m_lock_h[i-1];
            m_btn_h[i]  = m_btn_h[i-1];
        end
        m_lock_h[0] = pllLocked;
        m_btn_h[0]  = btnReset;
    endtask

    function automatic int m_released();
        int rel;
        rel = (m_n < POR) ? 0 : (m_n - POR) / GAP;
        if (rel > NCH) rel = NCH;
        return rel;
    endfunction

    function automatic logic [3:0] m_out();
        int full;
        if (m_soft_left > 0) return m_soft_mask;
        full = ~((1 << m_released()) - 1);
        return 4'(full);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            swResetReq = 1'b0;
            if (cmp_model) begin
                chk("rnd_out",   32'(resetOut),   32'(m_out()));
                chk("rnd_done",  32'(resetDone),  32'((m_released() == NCH) && (m_soft_left == 0)));
                chk("rnd_cause", 32'(resetCause), 32'(m_cause));
            end
        end
    endtask

    typedef struct {
        int         ncyc;
        logic       lock;
        logic       btn;
        logic       req;
        logic [3:0] mask;
        logic [3:0] out;
        logic       done;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[26];

    int lock_left;
    int btn_left;

    initial begin
        vecs[0]  = '{25, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 2'd0};
        vecs[1]  = '{1,  1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0, 2'd0};
        vecs[2]  = '{3,  1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0, 2'd0};
        vecs[3]  = '{1,  1'b1, 1'b0, 1'b0, 4'h0, 4'hC, 1'b0, 2'd0};
        vecs[4]  = '{4,  1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 2'd0};
        vecs[5]  = '{3,  1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 2'd0};
        vecs[6]  = '{1,  1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0};
        vecs[7]  = '{1,  1'b1, 1'b0, 1'b1, 4'hC, 4'hC, 1'b0, 2'd3};
        vecs[8]  = '{4,  1'b1, 1'b0, 1'b0, 4'h0, 4'hC, 1'b0, 2'd3};
        vecs[9]  = '{1,  1'b1, 1'b0, 1'b1, 4'h3, 4'hC, 1'b0, 2'd3};
        vecs[10] = '{1,  1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd3};
        vecs[11] = '{1,  1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd3};
        vecs[12] = '{2,  1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd3};
        vecs[13] = '{1,  1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 2'd1};
        vecs[14] = '{25, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 2'd1};
        vecs[15] = '{1,  1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0, 2'd1};
        vecs[16] = '{4,  1'b1, 1'b0, 1'b0, 4'h0, 4'hC, 1'b0, 2'd1};
        vecs[17] = '{8,  1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1};
        vecs[18] = '{5,  1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1};
        vecs[19] = '{10, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1};
        vecs[20] = '{9,  1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1};
        vecs[21] = '{1,  1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 2'd2};
        vecs[22] = '{20, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 2'd2};
        vecs[23] = '{26, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 2'd2};
        vecs[24] = '{1,  1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0, 2'd2};
        vecs[25] = '{12, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd2};

        reset = 1'b1; pllLocked = 1'b0; btnReset = 1'b0;
        swResetReq = 1'b0; swResetMask = 4'h0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_out",   32'(resetOut),   32'hF);
        chk("rst_done",  32'(resetDone),  32'h0);
        chk("rst_cause", 32'(resetCause), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 26; i++) begin
            pllLocked   = vecs[i].lock;
            btnReset    = vecs[i].btn;
            swResetReq  = vecs[i].req;
            swResetMask = vecs[i].mask;
            tick(vecs[i].ncyc);
            chk($sformatf("vec%0d_out", i),   32'(resetOut),   32'(vecs[i].out));
            chk($sformatf("vec%0d_done", i),  32'(resetDone),  32'(vecs[i].done));
            chk($sformatf("vec%0d_cause", i), 32'(resetCause), 32'(vecs[i].cause));
        end

        // Lock loss and software request reach the sequencer on the same edge.
        pllLocked = 1'b0;
        tick(2);
        chk("coin1_pre", 32'(resetOut), 32'h0);
        swResetReq = 1'b1; swResetMask = 4'hF;
        tick(1);
        chk("coin1_out",   32'(resetOut),   32'hF);
        chk("coin1_cause", 32'(resetCause), 32'h1);
        chk("coin1_done",  32'(resetDone),  32'h0);
        pllLocked = 1'b1;
        tick(40);
        chk("coin1_reseq", 32'(resetDone), 32'h1);
        swResetReq = 1'b1; swResetMask = 4'h1;
        tick(1);
        chk("soft1_cause", 32'(resetCause), 32'h3);
        chk("soft1_out",   32'(resetOut),   32'h1);
        tick(6);
        chk("soft1_end", 32'(resetOut), 32'h0);

        // Debounced button and lock loss become visible on the same edge.
        btnReset = 1'b1;
        tick(7);
        pllLocked = 1'b0;
        tick(2);
        chk("coin2_pre", 32'(resetOut), 32'h0);
        tick(1);
        chk("coin2_out",   32'(resetOut),   32'hF);
        chk("coin2_cause", 32'(resetCause), 32'h1);

        // Async reset after channel 1 has been released.
        btnReset = 1'b0; pllLocked = 1'b1;
        tick(32);
        chk("stage_out", 32'(resetOut), 32'hC);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("arst_out",   32'(resetOut),   32'hF);
        chk("arst_done",  32'(resetDone),  32'h0);
        chk("arst_cause", 32'(resetCause), 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic against the reference model.
        cmp_model = 1'b1;
        lock_left = 0;
        btn_left = 60;
        for (int i = 0; i < 3000; i++) begin
            if (lock_left == 0) begin
                if (pllLocked) begin
                    pllLocked = 1'b0;
                    lock_left = $urandom_range(1, 5);
                end else begin
                    pllLocked = 1'b1;
                    lock_left = $urandom_range(30, 200);
                end
            end
            lock_left--;
            if (btn_left == 0) begin
                if (btnReset) begin
                    btnReset = 1'b0;
                    btn_left = $urandom_range(40, 400);
                end else begin
                    btnReset = 1'b1;
                    btn_left = $urandom_range(1, 14);
                end
            end
            btn_left--;
            swResetReq  = ($urandom_range(0, 5) == 0);
            swResetMask = 4'($urandom_range(0, 15));
            tick(1);
        end
        cmp_model = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
